sae_stream_driver: RTL and testbench
====================================

Name: sae_stream_driver

Overview:
- Hardware initiator for the sae byte-crypto core; replaces the bench-style sequencing of keygen, encrypt and decrypt with synthesizable control.
- Accepts one command (op, key, length), pulls plaintext/ciphertext bytes from an input stream and issues one sae request per byte.
- Collects each sae response into a buffered output stream with last-marker, and reports completion, error class and byte count.

Parameters:
- LEN_W, 8, width of command byte count.
- TIMEOUT, 16, max cycles waiting for sae response before timeout error (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  driver idle, command accepted when both high
- cmd_op  in  2  01 keygen, 10 encrypt, 11 decrypt; 00 illegal
- cmd_key  in  8  private/public key for the command
- cmd_len  in  LEN_W  bytes to process (ignored for keygen)
- in_valid  in  1  input byte offered
- in_ready  out  1  input byte accepted when both high
- in_data  in  8  plaintext/ciphertext byte
- out_valid  out  1  result byte valid
- out_ready  in  1  consumer accepts result
- out_data  out  8  result byte
- out_last  out  1  marks final result byte of command
- sae_mode  out  2  to sae mode
- sae_data_input  out  8  to sae data_input
- sae_key_input  out  8  to sae key_input
- sae_inputs_valid  out  1  one-cycle request strobe to sae
- sae_data_output  in  8  from sae
- sae_output_ready  in  1  from sae
- sae_err_ptxt  in  1  from sae err_invalid_ptxt_char
- sae_err_seckey  in  1  from sae err_invalid_seckey
- sae_err_ctxt  in  1  from sae err_invalid_ctxt_char
- done  out  1  one-cycle pulse at command end
- err_code  out  3  0 none, 1 seckey, 2 ptxt, 3 ctxt, 4 timeout, 5 illegal op; held until next command accepted
- byte_count  out  LEN_W  result bytes emitted in current/last command

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all outputs 0 except cmd_ready=1; sae_mode=00; counters, latched key/op cleared. Reset mid-command aborts without done pulse; in-flight sae response ignored.
- States: IDLE, FETCH, ISSUE, WAIT, EMIT, DRAIN, FIN.
- IDLE: cmd_ready=1. On accept latch op/key/len, clear byte_count and err_code. op 00 -> FIN with err_code 5. keygen -> ISSUE with data 0x00. enc/dec with len 0 -> FIN, no sae request. Else -> FETCH.
- FETCH: in_ready=1; on accept latch byte -> ISSUE.
- ISSUE: sae_inputs_valid=1 exactly one cycle; sae_mode=op, sae_key_input=key, sae_data_input=latched byte -> WAIT, timer cleared.
- WAIT: sae_mode and key held (sae_mode=00 in all other states except ISSUE). Response = first cycle with sae_output_ready or any sae_err_*. Error priority seckey>ptxt>ctxt; on error set err_code, go DRAIN (keygen: FIN). Clean response: capture sae_data_output -> EMIT. Timer reaching TIMEOUT with no response: err_code 4 -> DRAIN/FIN.
- EMIT: out_valid=1, out_data held stable until out_ready; out_last=1 on final byte (keygen: always). On handshake byte_count++; more bytes -> FETCH, else FIN.
- DRAIN: in_ready=1; consume and discard remaining (len - consumed) input bytes so stream stays aligned; no output; then FIN.
- FIN: done=1 one cycle -> IDLE.
- Min per-byte latency: input accept N, sae_inputs_valid N+1, response >=N+2 (sae registered), out_valid on cycle after response.
- Exactly one sae request outstanding; no new request while out_valid unacknowledged.
- byte_count saturates at 2^LEN_W-1 (cannot exceed len by construction).

Test Plan:
- Keygen: op 01, key 0x2B; bench sae model returns 0xD5 one cycle after strobe -> single sae_inputs_valid pulse with mode 01, data 0x00; out_data 0xD5, out_last 1, done, err_code 0, byte_count 1.
- Encrypt "ABC" (0x41,0x42,0x43), len 3, model returns data^key, out_ready low 4 cycles on byte 2 -> outputs 0x6A,0x69,0x68 in order, out_data stable during stall, out_last only on 0x68, exactly 3 strobes.
- Decrypt len 4, model asserts sae_err_ctxt on byte 2 -> one output byte, err_code 3, bytes 3-4 consumed with no strobe, done pulse, byte_count 1.
- Model never responds, TIMEOUT 16 -> err_code 4 exactly 16 cycles after strobe, done, next command accepted normally.
- cmd_len 0 encrypt and op 00 -> no strobes, done next cycles, err_code 0 and 5 respectively.
- rst_n low during WAIT of byte 2 -> all outputs reset values next edge, late sae response ignored, cmd_ready 1.

Source files
------------

// File: rtl/sae_stream_driver.sv
// Streaming initiator for the sae byte-crypto core: takes one command, feeds input bytes
// to sae one request at a time and returns each result on a buffered output stream.
module sae_stream_driver #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_key,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [1:0]       sae_mode,
    output logic [7:0]       sae_data_input,
    output logic [7:0]       sae_key_input,
    output logic             sae_inputs_valid,
    input  logic [7:0]       sae_data_output,
    input  logic             sae_output_ready,
    input  logic             sae_err_ptxt,
    input  logic             sae_err_seckey,
    input  logic             sae_err_ctxt,
    output logic             done,
    output logic [2:0]       err_code,
    output logic [LEN_W-1:0] byte_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_KEYGEN  = 2'b01;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SECKEY  = 3'd1;
    localparam logic [2:0] ERR_PTXT    = 3'd2;
    localparam logic [2:0] ERR_CTXT    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_ILLOP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        EMIT,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [7:0]       key_q;
    logic [7:0]       data_q;
    logic [7:0]       result_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] consumed_q;
    logic [LEN_W-1:0] byte_count_q;
    logic [2:0]       err_q;
    logic [TW-1:0]    timer_q;

    logic is_keygen;
    logic all_consumed;
    logic last_byte;
    logic resp_err;
    logic resp_any;
    logic timed_out;

    assign is_keygen    = (op_q == OP_KEYGEN);
    assign all_consumed = (consumed_q == len_q);
    assign last_byte    = is_keygen || all_consumed;
    assign resp_err     = sae_err_seckey || sae_err_ptxt || sae_err_ctxt;
    assign resp_any     = sae_output_ready || resp_err;
    // Timer starts at 0 in the first WAIT cycle, so TIMEOUT-2 is the last cycle before
    // the error lands exactly TIMEOUT cycles after the request strobe.
    assign timed_out    = (timer_q == TW'(TIMEOUT - 2));

    assign err_code   = err_q;
    assign byte_count = byte_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cmd_ready        = 1'b0;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        out_data         = 8'h00;
        out_last         = 1'b0;
        sae_mode         = 2'b00;
        sae_data_input   = 8'h00;
        sae_key_input    = 8'h00;
        sae_inputs_valid = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_ILLEGAL) begin
                        state_nxt = FIN;
                    end else if (cmd_op == OP_KEYGEN) begin
                        state_nxt = ISSUE;
                    end else if (cmd_len == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                sae_inputs_valid = 1'b1;
                sae_mode         = op_q;
                sae_key_input    = key_q;
                sae_data_input   = data_q;
                state_nxt        = WAIT;
            end
            WAIT: begin
                sae_mode       = op_q;
                sae_key_input  = key_q;
                sae_data_input = data_q;
                if (resp_any && !resp_err) begin
                    state_nxt = EMIT;
                end else if (resp_err || timed_out) begin
                    // Unconsumed input must still be drained so the stream stays aligned.
                    state_nxt = last_byte ? FIN : DRAIN;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = result_q;
                out_last  = last_byte;
                if (out_ready) begin
                    state_nxt = last_byte ? FIN : FETCH;
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && (consumed_q + LEN_W'(1) == len_q)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= 2'b00;
            key_q        <= 8'h00;
            data_q       <= 8'h00;
            result_q     <= 8'h00;
            len_q        <= '0;
            consumed_q   <= '0;
            byte_count_q <= '0;
            err_q        <= ERR_NONE;
            timer_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q         <= cmd_op;
                        key_q        <= cmd_key;
                        len_q        <= cmd_len;
                        data_q       <= 8'h00;
                        consumed_q   <= '0;
                        byte_count_q <= '0;
                        err_q        <= (cmd_op == OP_ILLEGAL) ? ERR_ILLOP : ERR_NONE;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        consumed_q <= consumed_q + LEN_W'(1);
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                end
                WAIT: begin
                    if (sae_err_seckey) begin
                        err_q <= ERR_SECKEY;
                    end else if (sae_err_ptxt) begin
                        err_q <= ERR_PTXT;
                    end else if (sae_err_ctxt) begin
                        err_q <= ERR_CTXT;
                    end else if (sae_output_ready) begin
                        result_q <= sae_data_output;
                    end else if (timed_out) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready && (byte_count_q != {LEN_W{1'b1}})) begin
                        byte_count_q <= byte_count_q + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (in_valid) begin
                        consumed_q <= consumed_q + LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sae_stream_driver.sv
// Directed bench for sae_stream_driver with a small behavioural sae responder and
// stream feeder/collector; expected values are hand-computed per command.
module tb_sae_stream_driver;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [7:0]       cmd_key;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic [1:0]       sae_mode;
    logic [7:0]       sae_data_input;
    logic [7:0]       sae_key_input;
    logic             sae_inputs_valid;
    logic [7:0]       sae_data_output = 8'h00;
    logic             sae_output_ready = 1'b0;
    logic             sae_err_ptxt = 1'b0;
    logic             sae_err_seckey = 1'b0;
    logic             sae_err_ctxt = 1'b0;
    logic             done;
    logic [2:0]       err_code;
    logic [LEN_W-1:0] byte_count;

    always #5 clk = ~clk;

    sae_stream_driver #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sae_mode(sae_mode), .sae_data_input(sae_data_input), .sae_key_input(sae_key_input),
        .sae_inputs_valid(sae_inputs_valid), .sae_data_output(sae_data_output),
        .sae_output_ready(sae_output_ready), .sae_err_ptxt(sae_err_ptxt),
        .sae_err_seckey(sae_err_seckey), .sae_err_ctxt(sae_err_ctxt),
        .done(done), .err_code(err_code), .byte_count(byte_count)
    );

    int total = 0;
    int bad   = 0;

    // model_kind: 0 answer next cycle, 1 ctxt error on strobe err_at, 2 silent, 3 answer late
    int model_kind  = 0;
    int err_at      = 0;
    int strobe_base = 0;
    int strobe_cnt  = 0;
    int pcnt        = 0;
    int strobe_pc   = 0;
    int pend        = 0;
    logic [7:0] pend_val  = 8'h00;
    logic [1:0] last_mode = 2'b00;
    logic [7:0] last_data = 8'h00;
    logic [7:0] last_key  = 8'h00;

    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    logic       out_lq[$];

    function automatic logic [7:0] modelResp(input logic [1:0] m, input logic [7:0] d,
                                             input logic [7:0] k);
        return (m == 2'b01) ? 8'hD5 : (d ^ k);
    endfunction

    always @(posedge clk) begin
        pcnt             <= pcnt + 1;
        sae_output_ready <= 1'b0;
        sae_err_ctxt     <= 1'b0;
        if (pend != 0) begin
            if (pend == 1) begin
                sae_output_ready <= 1'b1;
                sae_data_output  <= pend_val;
            end
            pend <= pend - 1;
        end
        if (sae_inputs_valid) begin
            strobe_cnt <= strobe_cnt + 1;
            strobe_pc  <= pcnt;
            last_mode  <= sae_mode;
            last_data  <= sae_data_input;
            last_key   <= sae_key_input;
            if (model_kind == 0 || (model_kind == 1 && (strobe_cnt - strobe_base) != err_at)) begin
                sae_output_ready <= 1'b1;
                sae_data_output  <= modelResp(sae_mode, sae_data_input, sae_key_input);
            end else if (model_kind == 1) begin
                sae_err_ctxt <= 1'b1;
            end else if (model_kind == 3) begin
                pend     <= 4;
                pend_val <= modelResp(sae_mode, sae_data_input, sae_key_input);
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            out_lq.push_back(out_last);
        end
    end

    initial begin
        bit hs;
        in_valid = 1'b0;
        in_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs && in_q.size() > 0) void'(in_q.pop_front());
            in_valid = (in_q.size() > 0);
            in_data  = (in_q.size() > 0) ? in_q[0] : 8'h00;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] key,
                                 input logic [7:0] len);
        bit seen = 0;
        strobe_base = strobe_cnt;
        out_q.delete();
        out_lq.delete();
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_len   = len;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                seen = 1;
                break;
            end
        end
        checkOutput("cmdAccept", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        bit found;
        bit quiet;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_key   = 8'h00;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
        checkOutput("rstOutputs", {in_ready, out_valid, sae_inputs_valid, done, sae_mode},
                    32'd0);
        checkOutput("rstErr", 32'(err_code), 32'd0);
        checkOutput("rstCount", 32'(byte_count), 32'd0);
        rst_n = 1'b1;

        // keygen
        model_kind = 0;
        applyStimulus(2'b01, 8'h2B, 8'd0);
        waitDone(20, "kgDone");
        checkOutput("kgErr", 32'(err_code), 32'd0);
        checkOutput("kgCount", 32'(byte_count), 32'd1);
        checkOutput("kgStrobes", 32'(strobe_cnt - strobe_base), 32'd1);
        checkOutput("kgReq", {last_mode, last_data, last_key}, {2'b01, 8'h00, 8'h2B});
        checkOutput("kgOutN", 32'(out_q.size()), 32'd1);
        if (out_q.size() == 1) begin
            checkOutput("kgData", 32'(out_q[0]), 32'hD5);
            checkOutput("kgLast", 32'(out_lq[0]), 32'd1);
        end

        // encrypt "ABC" with a 4-cycle stall on byte 2
        in_q = '{8'h41, 8'h42, 8'h43};
        applyStimulus(2'b10, 8'h2B, 8'd3);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_q.size() == 1) begin
                found = 1;
                break;
            end
        end
        checkOutput("encByte1", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        checkOutput("encByte2Valid", 32'(found), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("encStall", {out_valid, out_data}, {1'b1, 8'h69});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDone(60, "encDone");
        checkOutput("encErr", 32'(err_code), 32'd0);
        checkOutput("encCount", 32'(byte_count), 32'd3);
        checkOutput("encStrobes", 32'(strobe_cnt - strobe_base), 32'd3);
        checkOutput("encOutN", 32'(out_q.size()), 32'd3);
        if (out_q.size() == 3) begin
            checkOutput("encData", {out_q[0], out_q[1], out_q[2]}, {8'h6A, 8'h69, 8'h68});
            checkOutput("encLast", {out_lq[0], out_lq[1], out_lq[2]}, {1'b0, 1'b0, 1'b1});
        end

        // decrypt with ctxt error on byte 2, remaining bytes drained
        model_kind = 1;
        err_at     = 1;
        in_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        applyStimulus(2'b11, 8'h10, 8'd4);
        waitDone(60, "decDone");
        checkOutput("decErr", 32'(err_code), 32'd3);
        checkOutput("decCount", 32'(byte_count), 32'd1);
        checkOutput("decStrobes", 32'(strobe_cnt - strobe_base), 32'd2);
        checkOutput("decDrained", 32'(in_q.size()), 32'd0);
        checkOutput("decOutN", 32'(out_q.size()), 32'd1);
        if (out_q.size() == 1) begin
            checkOutput("decData", {out_lq[0], out_q[0]}, {1'b0, 8'h45});
        end

        // timeout
        model_kind = 2;
        in_q = '{8'h11, 8'h22};
        applyStimulus(2'b10, 8'h01, 8'd2);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (err_code == 3'd4) begin
                found = 1;
                break;
            end
        end
        checkOutput("toSeen", 32'(found), 32'd1);
        checkOutput("toLatency", 32'(pcnt - strobe_pc), 32'(TIMEOUT));
        waitDone(20, "toDone");
        checkOutput("toErr", 32'(err_code), 32'd4);
        checkOutput("toStrobes", 32'(strobe_cnt - strobe_base), 32'd1);
        checkOutput("toDrained", 32'(in_q.size()), 32'd0);
        checkOutput("toCount", 32'(byte_count), 32'd0);

        // next command after timeout works normally
        model_kind = 0;
        in_q = '{8'h30};
        applyStimulus(2'b10, 8'h0F, 8'd1);
        waitDone(30, "postToDone");
        checkOutput("postToErr", 32'(err_code), 32'd0);
        checkOutput("postToOutN", 32'(out_q.size()), 32'd1);
        if (out_q.size() == 1) begin
            checkOutput("postToData", {out_lq[0], out_q[0]}, {1'b1, 8'h3F});
        end

        // zero-length encrypt
        applyStimulus(2'b10, 8'h33, 8'd0);
        waitDone(3, "len0Done");
        checkOutput("len0Err", 32'(err_code), 32'd0);
        checkOutput("len0Strobes", 32'(strobe_cnt - strobe_base), 32'd0);
        checkOutput("len0Count", 32'(byte_count), 32'd0);

        // illegal op
        applyStimulus(2'b00, 8'h33, 8'd5);
        waitDone(3, "illDone");
        checkOutput("illErr", 32'(err_code), 32'd5);
        checkOutput("illStrobes", 32'(strobe_cnt - strobe_base), 32'd0);

        // reset during WAIT of byte 2 with a late sae answer
        model_kind = 3;
        in_q = '{8'h41, 8'h42, 8'h43};
        applyStimulus(2'b10, 8'h2B, 8'd3);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (strobe_cnt - strobe_base == 2) begin
                found = 1;
                break;
            end
        end
        checkOutput("rstMidStrobe2", 32'(found), 32'd1);
        checkOutput("rstMidByte1", 32'(out_q.size()), 32'd1);
        rst_n = 1'b0;
        in_q.delete();
        @(negedge clk);
        checkOutput("rstMidReady", 32'(cmd_ready), 32'd1);
        checkOutput("rstMidOutputs",
                    {in_ready, out_valid, out_last, out_data, sae_inputs_valid, sae_mode,
                     sae_data_input, sae_key_input, done},
                    32'd0);
        checkOutput("rstMidErrCount", {err_code, byte_count}, 32'd0);
        rst_n = 1'b1;
        quiet = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || done || !cmd_ready) quiet = 0;
        end
        checkOutput("rstMidIgnored", 32'(quiet), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
